// File: rtl/block_config_sequencer.sv
// Serial configuration sequencer: assembles MEM_SIZE-bit words from a 1-bit
// valid/ready stream and strobes them one by one into a chain of latch blocks.
module block_config_sequencer #(
  parameter int MEM_SIZE      = 16,
  parameter int NUM_BLOCKS    = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] cen,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int STB_W = $clog2(STROBE_CYCLES + 1);

  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(MEM_SIZE - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [STB_W-1:0]      STB_LAST = STB_W'(STROBE_CYCLES - 1);
  localparam logic [NUM_BLOCKS-1:0] CEN_ONE  = NUM_BLOCKS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [BLK_W-1:0] blk_idx;
  logic [STB_W-1:0] stb_cnt;

  // Outputs are updated together with the state they belong to, so every
  // output is a plain flop with no path from the inputs.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      blk_idx    <= '0;
      stb_cnt    <= '0;
      config_out <= '0;
      cen        <= '0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_SHIFT;
            blk_idx   <= '0;
            bit_cnt   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_SHIFT: begin
          // cfg_ready is always high here, so a valid bit is a handshake
          if (cfg_valid) begin
            config_out <= {cfg_bit, config_out[MEM_SIZE-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state     <= S_STROBE;
              bit_cnt   <= '0;
              stb_cnt   <= '0;
              cfg_ready <= 1'b0;
              cen       <= CEN_ONE << blk_idx;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_STROBE: begin
          if (stb_cnt == STB_LAST) begin
            state <= S_HOLD;
            cen   <= '0;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          // One quiet cycle keeps config_out steady after the latch closes
          if (blk_idx == BLK_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_SHIFT;
            blk_idx   <= blk_idx + 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/block_config_sequencer.md
Name: block_config_sequencer

Overview:
- Loads configuration into a chain of NUM_BLOCKS block_config_latches instances from a serial bitstream.
- Assembles each MEM_SIZE-bit word from a 1-bit valid/ready stream.
- Presents the word on a shared config_out bus and strobes the one-hot cen of the target block.
- Advances through all blocks, then reports done. Sits between the bitstream loader and the SLICEL latch blocks.

Parameters:
- MEM_SIZE, 16, bits per latch block; width of config_out.
- NUM_BLOCKS, 8, number of latch blocks sequenced; width of cen.
- STROBE_CYCLES, 2, cycles cen is held high per block; must be >= 1.

Ports:
- cclk  input  1  configuration clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a configuration pass; sampled in IDLE and DONE only.
- cfg_bit  input  1  serial config data, LSB of each word first.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_ready  output  1  sequencer accepts cfg_bit this cycle.
- config_out  output  MEM_SIZE  shared word bus to every block's config_in.
- cen  output  NUM_BLOCKS  one-hot latch enable; bit i drives block i's cen.
- busy  output  1  high in SHIFT, STROBE and HOLD.
- done  output  1  high in DONE.

Behaviour:
Reset
- rst high at a cclk edge forces IDLE and clears everything: config_out=0, cen=0, cfg_ready=0, busy=0, done=0, bit counter=0, block index=0, strobe counter=0.
- Reset takes priority over every other event, including mid-strobe. cen must be 0 the cycle after rst is sampled.

Counter widths
- Bit counter: $clog2(MEM_SIZE), min 1.
- Block index: $clog2(NUM_BLOCKS), min 1.
- Strobe counter: $clog2(STROBE_CYCLES+1).

All outputs are registered or decoded from registered state only; no input-to-output combinational path.

FSM states (transitions taken at a cclk edge)
- IDLE
  - cfg_ready=0.
  - start=1 -> SHIFT; block index=0, bit counter=0.
- SHIFT
  - cfg_ready=1.
  - Handshake = cfg_valid & cfg_ready.
  - On handshake: config_out <= {cfg_bit, config_out[MEM_SIZE-1:1]}; bit counter +1.
  - After MEM_SIZE handshakes, the first bit received sits in config_out[0].
  - Handshake on bit counter==MEM_SIZE-1 -> STROBE; bit counter <= 0, strobe counter <= 0.
  - No handshake: hold all state.
- STROBE
  - cfg_ready=0; cfg_valid is ignored and no bit is consumed.
  - cen = one-hot(block index).
  - Exactly STROBE_CYCLES cycles, then -> HOLD.
  - config_out stays constant.
- HOLD
  - Exactly 1 cycle; cen=0, config_out unchanged. This guarantees data hold after the latch closes.
  - Block index==NUM_BLOCKS-1 -> DONE.
  - Otherwise block index +1 -> SHIFT.
- DONE
  - done=1; config_out keeps the last word.
  - start=1 -> SHIFT with block index=0 and bit counter=0 (new pass).

Boundary rules
- start in SHIFT, STROBE or HOLD: ignored.
- cen is never multi-hot, and is nonzero only in STROBE.
- config_out is stable from the last handshake through the end of HOLD.
- Per-block latency with no valid gaps: MEM_SIZE (SHIFT) + STROBE_CYCLES + 1 (HOLD).
- Full pass: NUM_BLOCKS x that, plus 1 cycle from start to SHIFT.

Test Plan:
Bench uses MEM_SIZE=4, NUM_BLOCKS=2, STROBE_CYCLES=2.
1. Reset: rst=1 for 2 cycles with random inputs -> config_out=0, cen=2'b00, cfg_ready=0, busy=0, done=0.
2. Full pass, no gaps:
   - start pulse; block0 bits 1,0,1,1 -> config_out=4'b1101, cen=2'b01 for exactly 2 cycles, then 1 cycle cen=0.
   - Block1 bits 0,1,1,0 -> config_out=4'b0110, cen=2'b10 for 2 cycles, then HOLD, then done=1, busy=0.
   - Total 15 cycles from start to done.
3. Valid gaps: same data as scenario 2 with cfg_valid low on alternate cycles -> identical config_out/cen sequence; bits are consumed only on handshake cycles.
4. Backpressure: cfg_valid=1 with bit=1 held throughout STROBE and HOLD -> cfg_ready=0 in those states, and the first bit of block1 is taken only on the first SHIFT cycle.
5. Reset mid-operation: rst asserted in the first STROBE cycle -> cen=2'b00 next cycle, IDLE, config_out=0. A subsequent start runs a clean pass from block0.
6. start handling:
   - start pulsed in SHIFT after 2 bits -> ignored, bit count continues.
   - start in DONE -> done=0, busy=1, block index 0, a second pass with new data reloads both blocks.
